sd_cmd_serial_host: RTL and testbench

Serial end of the SD command path, sitting between the command master and the CMD pad. It accepts a 40-bit command plus a settings word over a req/ack handshake and shifts out the 48-bit frame with CRC7. It then releases the line, captures the card response, checks it, and returns the result and a 16-bit status word over a second req/ack handshake. CLK_PAD_IO is the SD bit clock: one CMD bit per cycle.

---
 rtl/sd_cmd_serial_host.sv | 225 ++++++++++++++++++++++
 tb/tb_sd_cmd_serial_host.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_cmd_serial_host.sv
// Serial side of the SD command path: shifts a 48-bit command frame with CRC7 onto CMD,
// then captures and checks the card response and reports it over a req/ack handshake.
module sd_cmd_serial_host #(
    parameter int NCR_MAX = 64
) (
    input  logic        CLK_PAD_IO,
    input  logic        RST_PAD_I,
    input  logic        GO_IDLE,
    input  logic [15:0] SETTING_IN,
    input  logic [39:0] CMD_IN,
    input  logic        REQ_IN,
    input  logic        ACK_IN,
    output logic        ACK_OUT,
    output logic        REQ_OUT,
    output logic [39:0] CMD_OUT,
    output logic [15:0] STATUS,
    input  logic        cmd_dat_i,
    output logic        cmd_out_o,
    output logic        cmd_oe_o
);

    localparam int SYNC_STAGES = 2;
    localparam logic [7:0] NCR_LAST = 8'(NCR_MAX - 1);

    typedef enum logic [2:0] {IDLE, TX, TURN, WAIT_START, RX, REPORT} state_t;

    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
        logic fb;
        fb = crc[6] ^ din;
        return {crc[5:3], crc[2] ^ fb, crc[1:0], fb};
    endfunction

    function automatic logic [15:0] status_word(input logic done, input logic crc_ok,
                                                input logic timeout);
        return {9'd0, done, crc_ok, timeout, 4'd0};
    endfunction

    state_t                   state_q, state_d;
    logic [SYNC_STAGES-1:0]   req_sync_q, req_sync_d;
    logic [SYNC_STAGES-1:0]   ack_sync_q, ack_sync_d;
    logic                     req_prev_q, req_prev_d;
    logic [7:0]               cnt_q, cnt_d;
    logic [6:0]               crc_q, crc_d;
    logic                     crc_ok_q, crc_ok_d;
    logic [39:0]              cmd_q, cmd_d;
    logic [10:0]              setting_q, setting_d;
    logic                     ack_out_q, ack_out_d;
    logic                     req_out_q, req_out_d;
    logic [39:0]              rsp_q, rsp_d;
    logic [15:0]              status_q, status_d;
    logic                     pad_out_q, pad_out_d;
    logic                     pad_oe_q, pad_oe_d;

    logic req_s, ack_s, no_rsp, long_rsp, crc_valid;
    logic unused_setting;

    assign unused_setting = ^SETTING_IN[15:11];
    assign req_s     = req_sync_q[SYNC_STAGES-1];
    assign ack_s     = ack_sync_q[SYNC_STAGES-1];
    assign no_rsp    = (setting_q[6:0] == 7'd0);
    assign long_rsp  = (setting_q[6:0] == 7'd127);
    assign crc_valid = ~setting_q[7] | long_rsp | crc_ok_q;

    always_comb begin
        // NOTE: every _d gets its hold value first, so no path through the case infers a latch.
        state_d    = state_q;
        req_sync_d = {req_sync_q[SYNC_STAGES-2:0], REQ_IN};
        ack_sync_d = {ack_sync_q[SYNC_STAGES-2:0], ACK_IN};
        req_prev_d = req_s;
        cnt_d      = cnt_q;
        crc_d      = crc_q;
        crc_ok_d   = crc_ok_q;
        cmd_d      = cmd_q;
        setting_d  = setting_q;
        ack_out_d  = ack_out_q;
        req_out_d  = req_out_q;
        rsp_d      = rsp_q;
        status_d   = status_q;
        pad_out_d  = 1'b1;
        pad_oe_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (!ack_s) ack_out_d = 1'b1;
                if (req_s && !req_prev_q && ack_out_q) begin
                    cmd_d     = CMD_IN;
                    setting_d = SETTING_IN[10:0];
                    crc_d     = 7'd0;
                    cnt_d     = 8'd0;
                    ack_out_d = 1'b0;
                    status_d  = 16'd0;
                    pad_oe_d  = 1'b1;
                    pad_out_d = CMD_IN[39];
                    state_d   = TX;
                end
            end
            TX: begin
                // Command bits leave from cmd_q[39]; after bit 39 the CRC register is shifted out.
                pad_oe_d = 1'b1;
                cnt_d    = cnt_q + 8'd1;
                if (cnt_q < 8'd40) begin
                    cmd_d = {cmd_q[38:0], 1'b0};
                    crc_d = crc7_step(crc_q, cmd_q[39]);
                end else begin
                    crc_d = {crc_q[5:0], 1'b0};
                end
                if (cnt_q < 8'd39)       pad_out_d = cmd_q[38];
                else if (cnt_q == 8'd39) pad_out_d = crc_d[6];
                else if (cnt_q < 8'd46)  pad_out_d = crc_q[5];
                else if (cnt_q == 8'd46) pad_out_d = 1'b1;
                else begin
                    pad_oe_d = 1'b0;
                    cnt_d    = 8'd0;
                    if (no_rsp) begin
                        req_out_d = 1'b1;
                        status_d  = status_word(1'b1, 1'b1, 1'b0);
                        state_d   = REPORT;
                    end else begin
                        state_d = TURN;
                    end
                end
            end
            TURN: begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == {5'd0, setting_q[10:8]} + 8'd1) begin
                    cnt_d   = 8'd0;
                    state_d = WAIT_START;
                end
            end
            WAIT_START: begin
                cnt_d = cnt_q + 8'd1;
                if (!cmd_dat_i) begin
                    cnt_d    = 8'd0;
                    crc_d    = 7'd0;
                    crc_ok_d = 1'b1;
                    rsp_d    = {rsp_q[38:0], 1'b0};
                    state_d  = RX;
                end else if (cnt_q == NCR_LAST) begin
                    req_out_d = 1'b1;
                    status_d  = status_word(1'b0, 1'b0, 1'b1);
                    state_d   = REPORT;
                end
            end
            RX: begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_q < 8'd39) begin
                    rsp_d = {rsp_q[38:0], cmd_dat_i};
                    crc_d = crc7_step(crc_q, cmd_dat_i);
                end else if (!long_rsp && cnt_q < 8'd46) begin
                    crc_ok_d = crc_ok_q & (cmd_dat_i == crc_q[6]);
                    crc_d    = {crc_q[5:0], 1'b0};
                end
                if (cnt_q == (long_rsp ? 8'd134 : 8'd46)) begin
                    req_out_d = 1'b1;
                    status_d  = status_word(1'b1, crc_valid, 1'b0);
                    state_d   = REPORT;
                end
            end
            REPORT: begin
                if (ack_s) begin
                    req_out_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Abort wins over everything, including an accept in the same cycle.
        if (GO_IDLE) begin
            state_d   = IDLE;
            pad_oe_d  = 1'b0;
            pad_out_d = 1'b1;
            req_out_d = 1'b0;
            ack_out_d = ack_out_q;
            status_d  = status_q;
            rsp_d     = rsp_q;
            cnt_d     = 8'd0;
        end
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK_PAD_IO or negedge RST_PAD_I) begin
        if (!RST_PAD_I) begin
            state_q    <= IDLE;
            req_sync_q <= '0;
            ack_sync_q <= '0;
            req_prev_q <= 1'b0;
            cnt_q      <= 8'd0;
            crc_q      <= 7'd0;
            crc_ok_q   <= 1'b0;
            cmd_q      <= 40'd0;
            setting_q  <= 11'd0;
            ack_out_q  <= 1'b0;
            req_out_q  <= 1'b0;
            rsp_q      <= 40'd0;
            status_q   <= 16'd0;
            pad_out_q  <= 1'b1;
            pad_oe_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_sync_q <= req_sync_d;
            ack_sync_q <= ack_sync_d;
            req_prev_q <= req_prev_d;
            cnt_q      <= cnt_d;
            crc_q      <= crc_d;
            crc_ok_q   <= crc_ok_d;
            cmd_q      <= cmd_d;
            setting_q  <= setting_d;
            ack_out_q  <= ack_out_d;
            req_out_q  <= req_out_d;
            rsp_q      <= rsp_d;
            status_q   <= status_d;
            pad_out_q  <= pad_out_d;
            pad_oe_q   <= pad_oe_d;
        end
    end

    assign ACK_OUT   = ack_out_q;
    assign REQ_OUT   = req_out_q;
    assign CMD_OUT   = rsp_q;
    assign STATUS    = status_q;
    assign cmd_out_o = pad_out_q;
    assign cmd_oe_o  = pad_oe_q;

endmodule

// File: tb/tb_sd_cmd_serial_host.sv
// Directed bench for sd_cmd_serial_host: a card model answers commands, and a monitor
// compares transmitted frames and status reports against queued expectations.
module tb_sd_cmd_serial_host;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        go_idle = 1'b0;
    logic [15:0] setting_in = 16'd0;
    logic [39:0] cmd_in = 40'd0;
    logic        req_in = 1'b0;
    logic        ack_in = 1'b0;
    logic        cmd_dat = 1'b1;
    logic        ack_out, req_out, cmd_out_o, cmd_oe_o;
    logic [39:0] cmd_out;
    logic [15:0] status;

    typedef struct {
        logic [47:0] frame;
        int          len;
    } frm_exp_t;

    typedef struct {
        logic [15:0] status;
        logic [39:0] cmd_out;
        bit          chk_cmd;
        int          lat;
        bit          from_start;
    } rsp_exp_t;

    frm_exp_t frm_q[$];
    rsp_exp_t rsp_q[$];
    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int start_cyc = 0;
    int frame_end_cyc = 0;

    sd_cmd_serial_host #(.NCR_MAX(64)) dut (
        .CLK_PAD_IO (clk),
        .RST_PAD_I  (rst_n),
        .GO_IDLE    (go_idle),
        .SETTING_IN (setting_in),
        .CMD_IN     (cmd_in),
        .REQ_IN     (req_in),
        .ACK_IN     (ack_in),
        .ACK_OUT    (ack_out),
        .REQ_OUT    (req_out),
        .CMD_OUT    (cmd_out),
        .STATUS     (status),
        .cmd_dat_i  (cmd_dat),
        .cmd_out_o  (cmd_out_o),
        .cmd_oe_o   (cmd_oe_o)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // CRC7 by long division of data*x^7 by x^7+x^3+1.
    function automatic logic [6:0] crc7_ref(input logic [39:0] d);
        logic [46:0] r;
        r = {d, 7'd0};
        for (int i = 46; i >= 7; i--)
            if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
        return r[6:0];
    endfunction

    function automatic logic sig(input int sel);
        case (sel)
            0:       return ack_out;
            1:       return req_out;
            default: return cmd_oe_o;
        endcase
    endfunction

    task automatic wait_neg(input int sel, input logic val, input int budget, input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (sig(sel) !== val && n < budget);
        check(name, 64'(sig(sel)), 64'(val));
    endtask

    task automatic push_frame(input logic [47:0] frame, input int len);
        frm_exp_t e;
        e.frame = frame;
        e.len   = len;
        frm_q.push_back(e);
    endtask

    task automatic push_rsp(input logic [15:0] st, input logic [39:0] co, input bit chk_cmd,
                            input int lat, input bit from_start);
        rsp_exp_t e;
        e.status     = st;
        e.cmd_out    = co;
        e.chk_cmd    = chk_cmd;
        e.lat        = lat;
        e.from_start = from_start;
        rsp_q.push_back(e);
    endtask

    // Monitor: collects frames while cmd_oe_o is high and checks every rising REQ_OUT.
    initial begin : monitor
        logic [47:0] cap;
        int          nbits;
        bit          in_frame;
        logic        req_prev;
        frm_exp_t    fe;
        rsp_exp_t    re;
        cap = '0; nbits = 0; in_frame = 0; req_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (cmd_oe_o === 1'b1) begin
                cap = {cap[46:0], cmd_out_o};
                nbits++;
                in_frame = 1;
            end else if (in_frame) begin
                in_frame = 0;
                frame_end_cyc = cyc;
                check("frame_expected", 64'(frm_q.size() > 0), 64'd1);
                if (frm_q.size() > 0) begin
                    fe = frm_q.pop_front();
                    check("frame_len", 64'(nbits), 64'(fe.len));
                    check("frame_bits", 64'(cap & ((48'd1 << nbits) - 48'd1)),
                          64'(fe.frame >> (48 - fe.len)));
                end
                cap = '0;
                nbits = 0;
            end
            if (req_out === 1'b1 && req_prev !== 1'b1) begin
                check("report_expected", 64'(rsp_q.size() > 0), 64'd1);
                if (rsp_q.size() > 0) begin
                    re = rsp_q.pop_front();
                    check("status", 64'(status), 64'(re.status));
                    if (re.chk_cmd) check("cmd_out", 64'(cmd_out), 64'(re.cmd_out));
                    if (re.lat >= 0)
                        check("report_latency",
                              64'(cyc - (re.from_start ? start_cyc : frame_end_cyc)),
                              64'(re.lat));
                end
            end
            req_prev = req_out;
        end
    end

    // One command: request, optional abort, card response, then the report handshake.
    task automatic run_cmd(input logic [39:0] cmd, input logic [15:0] setting,
                           input logic [135:0] rsp, input int rsp_len,
                           input int go_idle_bit, input int rst_bit, input bit hold_req);
        wait_neg(0, 1'b1, 200, "ack_out_ready");
        cmd_in     = cmd;
        setting_in = setting;
        req_in     = 1'b1;
        wait_neg(2, 1'b1, 50, "tx_start");
        if (!hold_req) req_in = 1'b0;
        if (go_idle_bit >= 0) begin
            repeat (go_idle_bit) @(negedge clk);
            go_idle = 1'b1;
            @(negedge clk);
            check("go_idle_oe", 64'(cmd_oe_o), 64'd0);
            check("go_idle_out", 64'(cmd_out_o), 64'd1);
            go_idle = 1'b0;
            repeat (5) @(negedge clk);
            check("go_idle_no_report", 64'(req_out), 64'd0);
            return;
        end
        wait_neg(2, 1'b0, 60, "tx_end");
        if (rsp_len > 0) begin
            repeat (4) @(negedge clk);
            for (int i = 0; i < rsp_len; i++) begin
                @(negedge clk);
                if (i == 0) start_cyc = cyc;
                if (i == rst_bit) begin
                    rst_n = 1'b0;
                    cmd_dat = 1'b1;
                    #1;
                    check("rst_oe", 64'(cmd_oe_o), 64'd0);
                    check("rst_out", 64'(cmd_out_o), 64'd1);
                    check("rst_req_out", 64'(req_out), 64'd0);
                    check("rst_status", 64'(status), 64'd0);
                    check("rst_cmd_out", 64'(cmd_out), 64'd0);
                    repeat (2) @(negedge clk);
                    rst_n = 1'b1;
                    return;
                end
                cmd_dat = rsp[135 - i];
            end
            @(negedge clk);
            cmd_dat = 1'b1;
        end
        wait_neg(1, 1'b1, 400, "report_raised");
        ack_in = 1'b1;
        wait_neg(1, 1'b0, 20, "report_cleared");
        ack_in = 1'b0;
        wait_neg(0, 1'b1, 20, "ack_out_return");
        if (hold_req) begin
            repeat (10) @(negedge clk);
            check("no_retrigger_ack", 64'(ack_out), 64'd1);
            check("no_retrigger_oe", 64'(cmd_oe_o), 64'd0);
            req_in = 1'b0;
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        logic [39:0]  r1;
        logic [47:0]  r1_frm, r1_bad, f_cmd13;
        logic [135:0] r2;
        r1      = {2'b00, 6'd17, 32'h0000_0900};
        r1_frm  = {r1, crc7_ref(r1), 1'b1};
        r1_bad  = r1_frm ^ 48'h8;
        r2      = {8'h3F, 120'h0123456789ABCDEF_FEDCBA98765432, 7'h55, 1'b1};
        f_cmd13 = {40'h4D_0001_0000, crc7_ref(40'h4D_0001_0000), 1'b1};

        repeat (3) @(negedge clk);
        check("reset_ack_out", 64'(ack_out), 64'd0);
        check("reset_req_out", 64'(req_out), 64'd0);
        check("reset_cmd_out", 64'(cmd_out), 64'd0);
        check("reset_status", 64'(status), 64'd0);
        check("reset_pad_out", 64'(cmd_out_o), 64'd1);
        check("reset_pad_oe", 64'(cmd_oe_o), 64'd0);
        rst_n = 1'b1;

        // CMD0, no response; REQ_IN held high to prove no re-trigger.
        push_frame(48'h40_0000_0000_95, 48);
        push_rsp(16'h0060, 40'd0, 1'b0, 0, 1'b0);
        run_cmd(40'h40_0000_0000, 16'h0000, '0, 0, -1, -1, 1'b1);

        // CMD17 with a valid short response.
        push_frame(48'h51_0000_0000_55, 48);
        push_rsp(16'h0060, r1, 1'b1, 48, 1'b1);
        run_cmd(40'h51_0000_0000, 16'h00A8, {r1_frm, 88'd0}, 48, -1, -1, 1'b0);

        // Corrupted response CRC, checked and then unchecked.
        push_frame(48'h51_0000_0000_55, 48);
        push_rsp(16'h0040, r1, 1'b1, 48, 1'b1);
        run_cmd(40'h51_0000_0000, 16'h00A8, {r1_bad, 88'd0}, 48, -1, -1, 1'b0);
        push_frame(48'h51_0000_0000_55, 48);
        push_rsp(16'h0060, r1, 1'b1, 48, 1'b1);
        run_cmd(40'h51_0000_0000, 16'h0028, {r1_bad, 88'd0}, 48, -1, -1, 1'b0);

        // Silent card with turnaround 3: timeout after 3+2+64 cycles, CMD_OUT untouched.
        push_frame(f_cmd13, 48);
        push_rsp(16'h0010, r1, 1'b1, 69, 1'b0);
        run_cmd(40'h4D_0001_0000, 16'h03A8, '0, 0, -1, -1, 1'b0);

        // CMD2 with a 136-bit long response.
        push_frame(48'h42_0000_0000_4D, 48);
        push_rsp(16'h0060, 40'h3F_0123_4567, 1'b1, 136, 1'b1);
        run_cmd(40'h42_0000_0000, 16'h00FF, r2, 136, -1, -1, 1'b0);

        // Abort at TX bit 20, then a clean CMD0.
        push_frame(48'h51_0000_0000_55, 21);
        run_cmd(40'h51_0000_0000, 16'h00A8, {r1_frm, 88'd0}, 48, 20, -1, 1'b0);
        push_frame(48'h40_0000_0000_95, 48);
        push_rsp(16'h0060, 40'd0, 1'b0, 0, 1'b0);
        run_cmd(40'h40_0000_0000, 16'h0000, '0, 0, -1, -1, 1'b0);

        // Reset in the middle of a response, then a full CMD17.
        push_frame(48'h51_0000_0000_55, 48);
        run_cmd(40'h51_0000_0000, 16'h00A8, {r1_frm, 88'd0}, 48, -1, 20, 1'b0);
        push_frame(48'h51_0000_0000_55, 48);
        push_rsp(16'h0060, r1, 1'b1, 48, 1'b1);
        run_cmd(40'h51_0000_0000, 16'h00A8, {r1_frm, 88'd0}, 48, -1, -1, 1'b0);

        repeat (5) @(negedge clk);
        check("frames_outstanding", 64'(frm_q.size()), 64'd0);
        check("reports_outstanding", 64'(rsp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
